pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of all address datapaths.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_sel  input  3  next-PC select: 0 NONE (hold), 1 ADD4, 2 JAL, 3 JALR, 4 BRANCH, 5-7 treated as NONE.
REQ-006 taken  input  1  branch outcome; used only with BRANCH.
REQ-007 stall  input  1  freezes PC update while high.
REQ-008 rs1  input  XLEN  register operand for JALR.
REQ-009 imm  input  XLEN  sign-extended immediate offset.
REQ-010 trap  input  1  trap request, highest priority.
REQ-011 trap_vec  input  XLEN  trap handler address.
REQ-012 pc  output  XLEN  current fetch PC (registered).
REQ-013 redirect  output  1  one-cycle pulse when pc changes by other than +4.
REQ-014 misalign  output  1  one-cycle pulse when a redirect target is misaligned.
REQ-015 bad_addr  output  XLEN  last rejected misaligned target, held until the next misalign.

Function
REQ-016 Targets: ADD4 = pc+4; JAL = pc+imm; JALR = (rs1+imm) with bit0 cleared; BRANCH = pc+imm if taken, else pc+4; trap = trap_vec; all sums wrap modulo 2^XLEN.
REQ-017 Priority: trap > pending redirect > pc_sel.
REQ-018 Without stall, pc SHALL take the selected target on the next rising edge (latency 1).
REQ-019 With stall high and trap low, pc SHALL hold; NONE SHALL also hold pc.
REQ-020 JAL, JALR or taken BRANCH arriving while stall is high SHALL be captured in a one-entry pending register (target plus valid); ADD4 and not-taken BRANCH during stall SHALL be dropped.
REQ-021 On the first edge with stall low, a valid pending target SHALL load into pc and the pending entry SHALL clear; pc_sel in that cycle SHALL be ignored.
REQ-022 A second redirect during the same stall SHALL overwrite the pending entry (youngest wins).
REQ-023 trap SHALL load trap_vec on the next edge regardless of stall and SHALL clear any pending entry.
REQ-024 redirect SHALL be high for exactly the cycle after pc loads a JAL, JALR, taken BRANCH, pending or trap target.
REQ-025 Wrap-around: pc = 32'hFFFF_FFFC with ADD4 SHALL yield 32'h0000_0000, with no flag raised.

Reset
REQ-026 While rst is high: pc = RESET_VEC, redirect = 0, misalign = 0, bad_addr = 0, pending entry invalid.
REQ-027 Asserting rst mid-stall or mid-pending SHALL discard the pending target immediately.
REQ-028 On the first edge after rst falls, pc SHALL update normally from pc_sel.

Configuration
REQ-029 Macro PC_GEN_MISALIGN_EN defined: a non-trap target with bits[1:0] != 0 SHALL NOT load into pc or pending; pc holds, misalign pulses one cycle, and bad_addr captures the target.
REQ-030 Macro PC_GEN_MISALIGN_EN undefined: misalign is tied to 0, bad_addr is tied to 0, and targets load with bits[1:0] forced to 00.
REQ-031 The trap_vec value SHALL never be checked for alignment in either configuration.

Verification
REQ-032 Reset, then 4 cycles of ADD4 -> pc = 0, 4, 8, C, 10; redirect stays 0.
REQ-033 pc = 10, imm = 8, JAL -> pc = 18 and redirect pulses; then rs1 = 8, imm = 8, JALR -> pc = 10.
REQ-034 pc = 10, stall held 3 cycles with BRANCH, taken = 1, imm = 20 -> pc holds 10; on release pc = 30 with a single redirect pulse.
REQ-035 Stall with a pending target, trap = 1, trap_vec = 100 -> pc = 100 next edge; pending cleared, so after stall release pc continues from 100.
REQ-036 PC_GEN_MISALIGN_EN defined, pc = 0, JAL imm = 6 -> pc stays 0, misalign pulses, bad_addr = 6; undefined -> pc = 4.
REQ-037 Assert rst during pending redirect -> pc = RESET_VEC, and no redirect after rst release.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: sequential, jump, branch and trap next-PC selection,
// with a one-entry pending redirect held across stalls. Optional macro: PC_GEN_MISALIGN_EN.
module pc_gen #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      pc_sel,
  input  logic            taken,
  input  logic            stall,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  localparam logic [2:0] SEL_ADD4   = 3'd1;
  localparam logic [2:0] SEL_JAL    = 3'd2;
  localparam logic [2:0] SEL_JALR   = 3'd3;
  localparam logic [2:0] SEL_BRANCH = 3'd4;

  localparam logic [XLEN-1:0] STEP     = XLEN'(4);
  localparam logic [XLEN-1:0] CLR_BIT0 = {{(XLEN-1){1'b1}}, 1'b0};

  // K_SEQ moves by +4 (no redirect); K_JUMP changes flow and may be held pending.
  typedef enum logic [1:0] {
    K_HOLD,
    K_SEQ,
    K_JUMP
  } kind_e;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_v_q, pend_v_d;
  logic [XLEN-1:0] pend_t_q, pend_t_d;
  logic            redirect_q, redirect_d;

  kind_e           sel_kind;
  logic [XLEN-1:0] sel_tgt;
  logic [XLEN-1:0] load_tgt;
  logic            tgt_bad;

  always_comb begin
    sel_kind = K_HOLD;
    sel_tgt  = pc_q;
    case (pc_sel)
      SEL_ADD4: begin
        sel_kind = K_SEQ;
        sel_tgt  = pc_q + STEP;
      end
      SEL_JAL: begin
        sel_kind = K_JUMP;
        sel_tgt  = pc_q + imm;
      end
      SEL_JALR: begin
        sel_kind = K_JUMP;
        sel_tgt  = (rs1 + imm) & CLR_BIT0;
      end
      SEL_BRANCH: begin
        if (taken) begin
          sel_kind = K_JUMP;
          sel_tgt  = pc_q + imm;
        end else begin
          sel_kind = K_SEQ;
          sel_tgt  = pc_q + STEP;
        end
      end
      default: begin
        sel_kind = K_HOLD;
        sel_tgt  = pc_q;
      end
    endcase
  end

`ifdef PC_GEN_MISALIGN_EN
  // Misaligned targets are rejected outright rather than silently rounded.
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  assign tgt_bad  = |sel_tgt[1:0];
  assign load_tgt = sel_tgt;
`else
  assign tgt_bad  = 1'b0;
  assign load_tgt = sel_tgt & ~XLEN'(3);
`endif

  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_t_d   = pend_t_q;
    redirect_d = 1'b0;
`ifdef PC_GEN_MISALIGN_EN
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;
`endif
    if (trap) begin
      pc_d       = trap_vec;
      pend_v_d   = 1'b0;
      redirect_d = 1'b1;
    end else if (stall) begin
      // Only flow changes survive a stall; sequential steps are refetched later.
      if (sel_kind == K_JUMP) begin
        if (tgt_bad) begin
`ifdef PC_GEN_MISALIGN_EN
          misalign_d = 1'b1;
          bad_addr_d = sel_tgt;
`endif
        end else begin
          pend_v_d = 1'b1;
          pend_t_d = load_tgt;
        end
      end
    end else if (pend_v_q) begin
      pc_d       = pend_t_q;
      pend_v_d   = 1'b0;
      redirect_d = 1'b1;
    end else if (sel_kind != K_HOLD) begin
      if (tgt_bad) begin
`ifdef PC_GEN_MISALIGN_EN
        misalign_d = 1'b1;
        bad_addr_d = sel_tgt;
`endif
      end else begin
        pc_d       = load_tgt;
        redirect_d = (sel_kind == K_JUMP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_t_q   <= pend_t_d;
      redirect_q <= redirect_d;
    end
  end

`ifdef PC_GEN_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;
`else
  assign misalign = 1'b0;
  assign bad_addr = '0;
`endif

  assign pc       = pc_q;
  assign redirect = redirect_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: per-cycle comparison against a behavioural
// next-PC model plus hand-computed literal checkpoints along a directed sequence.
module tb_pc_gen;

  localparam logic [2:0] NONE = 3'd0, ADD4 = 3'd1, JAL = 3'd2, JALR = 3'd3, BRANCH = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pc_sel;
  logic        taken, stall, trap;
  logic [31:0] rs1, imm, trap_vec;
  logic [31:0] pc, bad_addr;
  logic        redirect, misalign;

  int total = 0;
  int bad   = 0;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .taken(taken), .stall(stall),
    .rs1(rs1), .imm(imm), .trap(trap), .trap_vec(trap_vec),
    .pc(pc), .redirect(redirect), .misalign(misalign), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        pv;
    logic [31:0] pt;
    logic        redir;
    logic        mis;
    logic [31:0] bad;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s);
    mstate_t     n;
    logic [31:0] tgt;
    logic        jump, moves;
    n       = s;
    n.redir = 1'b0;
    n.mis   = 1'b0;
    if (trap) begin
      n.pc = trap_vec; n.pv = 1'b0; n.redir = 1'b1;
      return n;
    end
    if (!stall && s.pv) begin
      n.pc = s.pt; n.pv = 1'b0; n.redir = 1'b1;
      return n;
    end
    moves = 1'b1;
    jump  = 1'b1;
    tgt   = s.pc;
    case (pc_sel)
      ADD4:   begin tgt = s.pc + 32'd4; jump = 1'b0; end
      JAL:    tgt = s.pc + imm;
      JALR:   tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      BRANCH: if (taken) tgt = s.pc + imm; else begin tgt = s.pc + 32'd4; jump = 1'b0; end
      default: moves = 1'b0;
    endcase
    if (!moves) return n;
    if (stall && !jump) return n;
`ifdef PC_GEN_MISALIGN_EN
    if (tgt[1:0] != 2'b00) begin
      n.mis = 1'b1; n.bad = tgt;
      return n;
    end
`else
    tgt[1:0] = 2'b00;
`endif
    if (stall) begin
      n.pv = 1'b1; n.pt = tgt;
    end else begin
      n.pc = tgt; n.redir = jump;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic run_chk = 1'b0;

  always @(negedge clk) begin
    if (run_chk) begin
      check("model_pc",       pc,                 m.pc);
      check("model_redirect", {31'b0, redirect},  {31'b0, m.redir});
      check("model_misalign", {31'b0, misalign},  {31'b0, m.mis});
      check("model_bad_addr", bad_addr,           m.bad);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [2:0] sel, input logic tk, input logic st,
                      input logic [31:0] im, input logic [31:0] r1);
    @(negedge clk); #1;
    rst = 1'b0; pc_sel = sel; taken = tk; stall = st; imm = im; rs1 = r1; trap = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic step_trap(input logic st, input logic [31:0] tv);
    @(negedge clk); #1;
    rst = 1'b0; pc_sel = NONE; stall = st; trap = 1'b1; trap_vec = tv;
    @(posedge clk); #2;
    trap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; pc_sel = NONE; taken = 1'b0; stall = 1'b0; trap = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [31:0] exp_pc, input logic exp_red);
    check({name, "_pc"}, pc, exp_pc);
    check({name, "_redirect"}, {31'b0, redirect}, {31'b0, exp_red});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; pc_sel = NONE; taken = 1'b0; stall = 1'b0; trap = 1'b0;
    rs1 = '0; imm = '0; trap_vec = '0;
    run_chk = 1'b1;
    do_reset();
    lit("reset", 32'h0, 1'b0);
    check("reset_misalign", {31'b0, misalign}, 32'h0);
    check("reset_bad_addr", bad_addr, 32'h0);

    // sequential fetch
    step(ADD4, 0, 0, 0, 0); lit("add4_1", 32'h4, 1'b0);
    step(ADD4, 0, 0, 0, 0); lit("add4_2", 32'h8, 1'b0);
    step(ADD4, 0, 0, 0, 0); lit("add4_3", 32'hC, 1'b0);
    step(ADD4, 0, 0, 0, 0); lit("add4_4", 32'h10, 1'b0);

    // jumps
    step(JAL, 0, 0, 32'h8, 0);   lit("jal", 32'h18, 1'b1);
    step(JALR, 0, 0, 32'h8, 32'h8); lit("jalr", 32'h10, 1'b1);
    step(NONE, 0, 0, 0, 0);      lit("none_hold", 32'h10, 1'b0);

    // taken branch held through a 3-cycle stall; pc_sel ignored on release
    for (int i = 0; i < 3; i++) begin
      step(BRANCH, 1, 1, 32'h20, 0); lit("stall_hold", 32'h10, 1'b0);
    end
    step(ADD4, 0, 0, 0, 0); lit("pend_release", 32'h30, 1'b1);
    step(NONE, 0, 0, 0, 0); lit("pend_after", 32'h30, 1'b0);

    // trap during stall with a pending target
    step(JAL, 0, 1, 32'h40, 0); lit("pend_trap_cap", 32'h30, 1'b0);
    step_trap(1'b1, 32'h100);   lit("trap", 32'h100, 1'b1);
    step(NONE, 0, 0, 0, 0);     lit("trap_cleared_pend", 32'h100, 1'b0);

    // youngest pending wins
    step(JAL, 0, 1, 32'h10, 0);
    step(JAL, 0, 1, 32'h20, 0);
    step(NONE, 0, 0, 0, 0);     lit("youngest", 32'h120, 1'b1);

    // sequential selections during stall are dropped
    step(ADD4, 0, 1, 0, 0);
    step(BRANCH, 0, 1, 32'h40, 0);
    step(NONE, 0, 0, 0, 0);     lit("dropped", 32'h120, 1'b0);

    // not-taken branch, reserved selects
    step(BRANCH, 0, 0, 32'h40, 0); lit("branch_nt", 32'h124, 1'b0);
    step(3'd6, 1, 0, 32'h40, 0);   lit("sel6_hold", 32'h124, 1'b0);
    step(3'd7, 1, 0, 32'h40, 0);   lit("sel7_hold", 32'h124, 1'b0);

    // wrap-around
    step(JALR, 0, 0, 32'h0, 32'hFFFF_FFFD); lit("jalr_bit0", 32'hFFFF_FFFC, 1'b1);
    step(ADD4, 0, 0, 0, 0);                 lit("wrap_add4", 32'h0, 1'b0);
    check("wrap_misalign", {31'b0, misalign}, 32'h0);
    step(JAL, 0, 0, 32'hFFFF_FFF8, 0);      lit("jal_neg", 32'hFFFF_FFF8, 1'b1);

    // misaligned jump target from pc = 0
    do_reset();
    step(JAL, 0, 0, 32'h6, 0);
`ifdef PC_GEN_MISALIGN_EN
    lit("mis_jal", 32'h0, 1'b0);
    check("mis_flag", {31'b0, misalign}, 32'h1);
    check("mis_bad_addr", bad_addr, 32'h6);
    step(NONE, 0, 0, 0, 0);
    check("mis_pulse_end", {31'b0, misalign}, 32'h0);
    check("mis_bad_held", bad_addr, 32'h6);
`else
    lit("mis_jal", 32'h4, 1'b1);
    check("mis_flag", {31'b0, misalign}, 32'h0);
    check("mis_bad_addr", bad_addr, 32'h0);
    step(NONE, 0, 0, 0, 0);
`endif

    // reset while a redirect is pending
    step(JAL, 0, 1, 32'h40, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    lit("async_rst", 32'h0, 1'b0);
    @(posedge clk); #2;
    step(NONE, 0, 0, 0, 0); lit("rst_no_redirect", 32'h0, 1'b0);
    step(ADD4, 0, 0, 0, 0); lit("post_rst_add4", 32'h4, 1'b0);

    @(negedge clk);
    #1;
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
